fifo_rd_stream: RTL and testbench

Read-side stream adapter for the async FIFO. It pops words from the FIFO read port, which has one-cycle read latency, and presents them as a valid/ready stream. A small prefetch buffer lets it sustain one word per cycle without a combinational path from `m_ready_i` to any output. It sits entirely in the read clock domain, between the async FIFO read port and the downstream consumer.

---
 rtl/fifo_rd_stream.sv | 129 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter from a 1-cycle-latency FIFO read port
// to a valid/ready stream. A small circular prefetch buffer decouples the
// pop decision from the consumer, so m_ready_i never reaches an output.
//
// Ports:
//   clk_i      read-domain clock (rising edge)
//   rst_i      asynchronous active-high reset
//   r_empty_i  FIFO empty flag
//   r_en_o     FIFO pop strobe
//   r_data_i   FIFO read data, valid the cycle after r_en_o
//   flush_i    synchronous flush of buffered and in-flight words
//   m_valid_o  stream valid (buffer non-empty)
//   m_ready_i  stream ready
//   m_data_o   stream data (buffer head)
//   occ_o      number of buffered words
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUF_DEPTH  = 3
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               r_empty_i,
    output logic                               r_en_o,
    input  logic [DATA_WIDTH-1:0]              r_data_i,
    input  logic                               flush_i,
    output logic                               m_valid_o,
    input  logic                               m_ready_i,
    output logic [DATA_WIDTH-1:0]              m_data_o,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     occ_o
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  inflight;
    logic                  discard;

    logic [PTR_W-1:0]      rd_ptr_next;
    logic [PTR_W-1:0]      wr_ptr_next;
    logic [CNT_W-1:0]      cnt_next;
    logic                  inflight_next;
    logic                  discard_next;

    logic [SUM_W-1:0]      pending;
    logic                  pop;
    logic                  arrival;
    logic                  fire;

    // Pointer increment with wrap at BUF_DEPTH-1.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pop only while buffered plus in-flight words leave room for one more;
    // reset gating keeps the strobe low while reset is held.
    always_comb begin
        pending = SUM_W'(cnt) + SUM_W'(inflight);
        pop     = !rst_i && !r_empty_i && !flush_i && (pending < SUM_W'(BUF_DEPTH));
        arrival = inflight && !discard && !flush_i;
        fire    = m_valid_o && m_ready_i;
    end

    assign r_en_o    = pop;
    assign m_valid_o = (cnt != '0);
    assign m_data_o  = mem[rd_ptr];
    assign occ_o     = cnt;

    // Next-state for pointers, occupancy and in-flight tracking.
    always_comb begin
        rd_ptr_next   = rd_ptr;
        wr_ptr_next   = wr_ptr;
        cnt_next      = cnt;
        inflight_next = pop;
        discard_next  = 1'b0;
        if (flush_i) begin
            rd_ptr_next  = '0;
            wr_ptr_next  = '0;
            cnt_next     = '0;
            // A word popped last cycle lands next edge and must be dropped.
            discard_next = inflight;
        end else begin
            if (arrival) begin
                wr_ptr_next = wrap_inc(wr_ptr);
            end
            if (fire) begin
                rd_ptr_next = wrap_inc(rd_ptr);
            end
            case ({arrival, fire})
                2'b10:   cnt_next = cnt + CNT_W'(1);
                2'b01:   cnt_next = cnt - CNT_W'(1);
                default: cnt_next = cnt;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr_next;
            wr_ptr   <= wr_ptr_next;
            cnt      <= cnt_next;
            inflight <= inflight_next;
            discard  <= discard_next;
        end
    end

    // Prefetch buffer storage; cleared on reset so m_data_o starts at 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (arrival) begin
            mem[wr_ptr] <= r_data_i;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: a depth-3 instance driven from a queue-based
// FIFO model with a scoreboard of popped-but-undelivered words, and a depth-2
// instance used for the throughput measurement.
module tb_fifo_rd_stream;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          r_empty, r_en, flush, m_valid, m_ready;
    logic [DW-1:0] r_data, m_data;
    logic [1:0]    occ;

    logic          e2, ren2, fl2, v2, rdy2;
    logic [DW-1:0] rd2, md2;
    logic [1:0]    occ2;

    fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(3)) dut (
        .clk_i(clk), .rst_i(rst), .r_empty_i(r_empty), .r_en_o(r_en),
        .r_data_i(r_data), .flush_i(flush), .m_valid_o(m_valid),
        .m_ready_i(m_ready), .m_data_o(m_data), .occ_o(occ)
    );

    fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .r_empty_i(e2), .r_en_o(ren2),
        .r_data_i(rd2), .flush_i(fl2), .m_valid_o(v2),
        .m_ready_i(rdy2), .m_data_o(md2), .occ_o(occ2)
    );

    int total = 0;
    int bad   = 0;

    // FIFO contents not yet popped, and words popped but not yet delivered.
    logic [DW-1:0] src[$];
    logic [DW-1:0] exp_q[$];
    bit            inflight_m;
    logic [DW-1:0] inflight_word;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    int            cyc = 0;
    bit            last_fire, last_pop, last_valid;
    logic [DW-1:0] last_out;

    // One clock of the depth-3 DUT; entered and left at a falling edge.
    task automatic tick();
        int exp_occ;
        bit exp_ren;
        r_empty = (src.size() == 0);
        #1;
        exp_occ = exp_q.size() - (inflight_m ? 1 : 0);
        exp_ren = !r_empty && !flush && (exp_q.size() < 3);
        total++;
        if (occ !== 2'(exp_occ)) begin
            bad++;
            $display("FAIL occ cyc=%0d got=%0d exp=%0d", cyc, occ, exp_occ);
        end
        total++;
        if (m_valid !== (exp_occ != 0)) begin
            bad++;
            $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, m_valid, exp_occ != 0);
        end
        total++;
        if (r_en !== exp_ren) begin
            bad++;
            $display("FAIL r_en cyc=%0d got=%b exp=%b", cyc, r_en, exp_ren);
        end
        if (prev_stall) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== prev_data) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/%h", cyc, m_valid, m_data, prev_data);
            end
        end
        last_valid = (m_valid === 1'b1);
        last_fire  = (m_valid === 1'b1) && (m_ready === 1'b1);
        if (last_fire) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_word cyc=%0d got=%h exp=none", cyc, m_data);
            end else begin
                if (m_data !== exp_q[0]) begin
                    bad++;
                    $display("FAIL order cyc=%0d got=%h exp=%h", cyc, m_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            last_out = m_data;
        end
        prev_stall = last_valid && !m_ready && !flush;
        prev_data  = m_data;
        if (flush) exp_q.delete();
        last_pop   = (r_en === 1'b1);
        inflight_m = 1'b0;
        if (last_pop && src.size() > 0) begin
            inflight_word = src.pop_front();
            exp_q.push_back(inflight_word);
            inflight_m = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        r_data = inflight_m ? inflight_word : DW'($urandom);
        cyc++;
    endtask

    // Let the consumer take everything; a budget overrun is reported.
    task automatic drain();
        m_ready = 1'b1;
        for (int k = 0; k < 100 && (src.size() > 0 || exp_q.size() > 0); k++) tick();
        total++;
        if (src.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d/%0d left exp=0/0", src.size(), exp_q.size());
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        inflight_m = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; r_empty = 1'b1; flush = 1'b0; m_ready = 1'b0; r_data = '0;
        e2 = 1'b1; fl2 = 1'b0; rdy2 = 1'b1; rd2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        total++; if (r_en !== 1'b0) begin bad++; $display("FAIL rst_r_en got=%b exp=0", r_en); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", m_valid); end
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occ); end
        total++; if (m_data !== '0) begin bad++; $display("FAIL rst_data got=%h exp=00", m_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stream();
        int first_pop = -1, first_valid = -1, first_fire = -1, last_fire_c = -1, nfire = 0;
        for (int i = 1; i <= 16; i++) src.push_back(DW'(i));
        m_ready = 1'b1;
        for (int k = 0; k < 60 && nfire < 16; k++) begin
            tick();
            if (last_pop && first_pop < 0) first_pop = cyc - 1;
            if (last_valid && first_valid < 0) first_valid = cyc - 1;
            if (last_fire) begin
                if (first_fire < 0) first_fire = cyc - 1;
                last_fire_c = cyc - 1;
                nfire++;
            end
        end
        total++;
        if (first_valid - first_pop != 2) begin
            bad++; $display("FAIL latency got=%0d exp=2", first_valid - first_pop);
        end
        total++;
        if (nfire != 16 || last_fire_c - first_fire != 15) begin
            bad++; $display("FAIL stream_rate got=%0d words in %0d cycles exp=16 in 16", nfire, last_fire_c - first_fire + 1);
        end
        #1;
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL stream_occ_end got=%0d exp=0", occ); end
        drain();
    endtask

    task automatic test_backpressure();
        int pops = 0, nfire = 0, first_fire = -1, last_fire_c = -1;
        logic [DW-1:0] first_word;
        for (int i = 0; i < 10; i++) src.push_back(DW'($urandom));
        first_word = src[0];
        m_ready = 1'b0;
        repeat (8) begin
            tick();
            if (last_pop) pops++;
        end
        #1;
        total++; if (pops != 3) begin bad++; $display("FAIL bp_pops got=%0d exp=3", pops); end
        total++; if (occ !== 2'd3) begin bad++; $display("FAIL bp_occ got=%0d exp=3", occ); end
        total++; if (m_data !== first_word) begin bad++; $display("FAIL bp_head got=%h exp=%h", m_data, first_word); end
        m_ready = 1'b1;
        for (int k = 0; k < 40 && nfire < 10; k++) begin
            tick();
            if (last_fire) begin
                if (first_fire < 0) first_fire = cyc - 1;
                last_fire_c = cyc - 1;
                nfire++;
            end
        end
        total++;
        if (nfire != 10 || last_fire_c - first_fire != 9) begin
            bad++; $display("FAIL bp_refill got=%0d words in %0d cycles exp=10 in 10", nfire, last_fire_c - first_fire + 1);
        end
        drain();
    endtask

    task automatic test_toggle();
        int nfire = 0;
        for (int i = 0; i < 20; i++) src.push_back(DW'($urandom));
        for (int k = 0; k < 120 && nfire < 20; k++) begin
            m_ready = (k % 2 == 0);
            tick();
            if (last_fire) nfire++;
        end
        total++;
        if (nfire != 20 || exp_q.size() != 0) begin
            bad++; $display("FAIL toggle_count got=%0d/%0d left exp=20/0", nfire, exp_q.size());
        end
        drain();
    endtask

    task automatic test_flush();
        logic [DW-1:0] after_word;
        bit got = 1'b0;
        for (int i = 0; i < 8; i++) src.push_back(DW'($urandom));
        m_ready = 1'b0;
        for (int k = 0; k < 10 && !(exp_q.size() == 3 && inflight_m); k++) tick();
        #1;
        total++; if (occ !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=2", occ); end
        after_word = src[0];
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occ); end
        m_ready = 1'b1;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            got = last_fire;
        end
        total++;
        if (!got || last_out !== after_word) begin
            bad++; $display("FAIL flush_next got=%h exp=%h", last_out, after_word);
        end
        drain();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 10; i++) src.push_back(DW'($urandom));
        m_ready = 1'b1;
        repeat (4) tick();
        #1;
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b exp=1", m_valid); end
        #1;
        rst = 1'b1;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", m_valid); end
        total++; if (r_en !== 1'b0) begin bad++; $display("FAIL arst_r_en got=%b exp=0", r_en); end
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL arst_occ got=%0d exp=0", occ); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drain();
    endtask

    task automatic test_depth2();
        bit popped, infl2 = 1'b0;
        int nxt_pop = 0, nxt_out = 0, fires_win = 0;
        e2 = 1'b0; rdy2 = 1'b1;
        for (int c = 0; c < 45; c++) begin
            #1;
            total++;
            if (ren2 === 1'b1 && int'(occ2) + int'(infl2) >= 2) begin
                bad++; $display("FAIL d2_pop_full cyc=%0d got occ=%0d inflight=%b exp no pop", c, occ2, infl2);
            end
            if (v2 === 1'b1) begin
                total++;
                if (md2 !== DW'(nxt_out)) begin
                    bad++; $display("FAIL d2_order cyc=%0d got=%h exp=%h", c, md2, DW'(nxt_out));
                end
                nxt_out++;
                if (c >= 12 && c < 42) fires_win++;
            end
            popped = (ren2 === 1'b1);
            @(posedge clk);
            @(negedge clk);
            if (popped) begin
                rd2 = DW'(nxt_pop);
                nxt_pop++;
            end else begin
                rd2 = DW'($urandom);
            end
            infl2 = popped;
        end
        e2 = 1'b1;
        total++;
        if (fires_win != 20) begin
            bad++; $display("FAIL d2_rate got=%0d exp=20 words per 30 cycles", fires_win);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_flush();
        test_async_reset();
        test_depth2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
